pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and stall controller for the 5-stage pipeline. Drives PC write enable, IF/ID write
//  enable and flush, and ID/EX bubble. Covers load-use, taken-branch and jump flushes, and
//  multi-cycle data-memory wait. A watchdog flags memory waits longer than MAX_WAIT cycles.
// PARAMETERS
//  MAX_WAIT  16  dmem wait cycles tolerated before mem_timeout is set
//  CNT_W     5   width of wait counter; must satisfy 2^CNT_W > MAX_WAIT
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  asynchronous reset, active-low
//  id_rs          in   5  source register 1 of the instruction in ID
//  id_rt          in   5  source register 2 of the instruction in ID
//  id_uses_rt     in   1  ID instruction reads id_rt
//  id_jump        in   1  ID holds J/JAL/JR (resolved in ID)
//  ex_mem_read    in   1  EX holds a load
//  ex_rt          in   5  destination register of the load in EX
//  ex_branch_tkn  in   1  branch in EX resolved taken
//  dmem_req       in   1  MEM stage access issued this cycle
//  dmem_ready     in   1  data memory completes access this cycle
//  pc_write       out  1  PC register enable
//  if_id_write    out  1  IF/ID register enable
//  if_id_flush    out  1  load NOP into IF/ID
//  id_ex_flush    out  1  load bubble (all controls 0) into ID/EX
//  pipe_freeze    out  1  hold ID/EX, EX/MEM, MEM/WB
//  mem_timeout    out  1  sticky, dmem wait exceeded MAX_WAIT
//  state          out  2  FSM state: 0 RUN, 1 DWAIT, 2 TIMEOUT
// BEHAVIOUR
//  Registered: state, wait_cnt[CNT_W-1:0], mem_timeout. All other outputs are
//   combinational from state and inputs, so they act in the same cycle.
//  Reset (reset=0, async): state=RUN, wait_cnt=0, mem_timeout=0.
//   While reset=0: pc_write=0, if_id_write=0, all flushes=0, pipe_freeze=0.
//  load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//  mem_stall = dmem_req & ~dmem_ready.
//  Output priority in RUN, highest first:
//   1 mem_stall: pc_write=0, if_id_write=0, pipe_freeze=1, no flushes. Next state DWAIT, wait_cnt=1.
//   2 ex_branch_tkn: pc_write=1, if_id_flush=1, id_ex_flush=1. Overrides load_use and id_jump.
//   3 id_jump: pc_write=1, if_id_flush=1, id_ex_flush=0.
//   4 load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble, because the
//     load moves to MEM next cycle and clears the condition.
//   5 none of the above: pc_write=1, if_id_write=1, flushes=0, pipe_freeze=0.
//  if_id_write=1 whenever if_id_flush=1, so the NOP is captured.
//  DWAIT: outputs as case 1 (full freeze). Branch, jump and load-use are ignored.
//   dmem_ready=1: next state RUN, wait_cnt=0. Freeze still holds this cycle; the stage
//    advances on the next edge.
//   Else if wait_cnt==MAX_WAIT: next state TIMEOUT, mem_timeout<=1.
//   Else wait_cnt<=wait_cnt+1. The counter saturates and never wraps.
//  TIMEOUT: full freeze, pc_write=0. Exit only by reset. mem_timeout is sticky.
//  Reset mid-DWAIT: returns to RUN immediately. No partial counter survives.
//  dmem_ready with no dmem_req: ignored.
// CONFIGURATION
//  HAZ_PERF_EN defined: adds outputs perf_lu_cnt[31:0], perf_flush_cnt[31:0] and
//   perf_wait_cnt[31:0].
//   perf_lu_cnt counts load-use bubbles. perf_flush_cnt counts cycles with if_id_flush=1.
//   perf_wait_cnt counts cycles in DWAIT.
//   All three reset to 0, wrap modulo 2^32, and freeze in TIMEOUT.
//  HAZ_PERF_EN undefined: the ports and counters are absent. Core behaviour is identical.
// TESTING
//  T1 ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, if_id_write=0,
//     id_ex_flush=1; next cycle (ex_mem_read=0) all normal.
//  T2 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; pc_write=1, id_ex_flush=0.
//  T3 ex_branch_tkn=1 with load_use true -> pc_write=1, if_id_flush=1, id_ex_flush=1.
//  T4 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> pipe_freeze=1 for 4 cycles,
//     state RUN->DWAIT->RUN, mem_timeout=0.
//  T5 dmem_ready held 0 for MAX_WAIT+2 cycles -> state=2, mem_timeout=1. Stays so until
//     reset=0, then state=0 and mem_timeout=0 asynchronously.
//  T6 (HAZ_PERF_EN) run T1, T3, T4 -> perf_lu_cnt=1, perf_flush_cnt=1, perf_wait_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, branch/jump flushes,
// dmem wait freeze and wait watchdog. Optional HAZ_PERF_EN adds three event counters.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_tkn,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_freeze,
  output logic       mem_timeout,
  output logic [1:0] state
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DWAIT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             mem_timeout_r;
  logic             load_use_s;
  logic             mem_stall_s;

  assign load_use_s  = ex_mem_read & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mem_stall_s = dmem_req & ~dmem_ready;
  assign state       = state_r;
  assign mem_timeout = mem_timeout_r;

  // Pipeline enables/flushes, decided in priority order from current state and hazards.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!reset) begin
      pc_write = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            pipe_freeze = 1'b1;
          end else if (ex_branch_tkn) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (id_jump) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (load_use_s) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ST_DWAIT:   pipe_freeze = 1'b1;
        ST_TIMEOUT: pipe_freeze = 1'b1;
        default:    pipe_freeze = 1'b1;
      endcase
    end
  end

  // Wait FSM with saturating wait counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_DWAIT;
            wait_cnt_r <= CNT_ONE_C;
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end
        end
        ST_DWAIT: begin
          // The request stays outstanding while frozen, so ready alone ends the wait.
          if (dmem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == MAX_WAIT_C) begin
            state_r       <= ST_TIMEOUT;
            mem_timeout_r <= 1'b1;
          end else if (wait_cnt_r != CNT_MAX_C) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE_C;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        ST_TIMEOUT: begin
          state_r       <= ST_TIMEOUT;
          mem_timeout_r <= 1'b1;
        end
        default: begin
          // An unreachable encoding is treated as a fault: lock up frozen.
          state_r       <= ST_TIMEOUT;
          mem_timeout_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  logic lu_bubble_s;
  logic perf_run_s;

  assign perf_run_s  = (state_r != ST_TIMEOUT);
  assign lu_bubble_s = (state_r == ST_RUN) & ~mem_stall_s & ~ex_branch_tkn & ~id_jump & load_use_s;

  // Event counters; they wrap naturally and hold once the watchdog has fired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_lu_cnt    <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_wait_cnt  <= 32'd0;
    end else if (perf_run_s) begin
      perf_lu_cnt    <= perf_lu_cnt    + {31'd0, lu_bubble_s};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, if_id_flush};
      perf_wait_cnt  <= perf_wait_cnt  + {31'd0, (state_r == ST_DWAIT)};
    end else begin
      perf_lu_cnt    <= perf_lu_cnt;
      perf_flush_cnt <= perf_flush_cnt;
      perf_wait_cnt  <= perf_wait_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; perf counter checks compile in with HAZ_PERF_EN.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_mem_read, ex_branch_tkn, dmem_req, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
  logic [1:0] state;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_wait_cnt;
`endif
  logic [4:0] outs;
  int checks = 0;
  int errors = 0;

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_tkn(ex_branch_tkn),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .state(state)
`ifdef HAZ_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0;
    ex_branch_tkn = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (outs !== 5'b00000) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, 5'b00000); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL run_idle got %b exp %b", outs, 5'b11000); end
  endtask

  task automatic test_load_use();
    tick(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    checks++; if (outs !== 5'b00010) begin errors++; $display("FAIL lu_rs got %b exp %b", outs, 5'b00010); end
    tick(); ex_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL lu_after got %b exp %b", outs, 5'b11000); end
    tick(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00010) begin errors++; $display("FAIL lu_rt got %b exp %b", outs, 5'b00010); end
    tick(); id_uses_rt = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", outs, 5'b11000); end
    tick(); clear_inputs();
  endtask

  task automatic test_zero_reg();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL lu_r0 got %b exp %b", outs, 5'b11000); end
    tick(); clear_inputs();
  endtask

  task automatic test_branch_jump();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch_tkn = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11110) begin errors++; $display("FAIL branch_over_lu got %b exp %b", outs, 5'b11110); end
    tick(); clear_inputs(); id_jump = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11100) begin errors++; $display("FAIL jump got %b exp %b", outs, 5'b11100); end
    tick(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    @(negedge clk);
    checks++; if (outs !== 5'b11100) begin errors++; $display("FAIL jump_over_lu got %b exp %b", outs, 5'b11100); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL after_flush got %b exp %b", outs, 5'b11000); end
    tick();
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b00001 || state !== 2'd0) begin errors++; $display("FAIL wait_c1 got %b/%0d exp 00001/0", outs, state); end
    tick(); ex_branch_tkn = 1'b1; id_jump = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00001 || state !== 2'd1) begin errors++; $display("FAIL wait_c2 got %b/%0d exp 00001/1", outs, state); end
    tick(); ex_branch_tkn = 1'b0; id_jump = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b00001 || state !== 2'd1) begin errors++; $display("FAIL wait_c3 got %b/%0d exp 00001/1", outs, state); end
    tick(); dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00001 || state !== 2'd1) begin errors++; $display("FAIL wait_c4 got %b/%0d exp 00001/1", outs, state); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (outs !== 5'b11000 || state !== 2'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL wait_exit got %b/%0d/%b exp 11000/0/0", outs, state, mem_timeout); end
    tick(); dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL ready_no_req got %b exp %b", outs, 5'b11000); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ready_no_req_state got %0d exp 0", state); end
`ifdef HAZ_PERF_EN
    checks++; if (perf_lu_cnt !== 32'd2) begin errors++; $display("FAIL perf_lu got %0d exp 2", perf_lu_cnt); end
    checks++; if (perf_flush_cnt !== 32'd3) begin errors++; $display("FAIL perf_flush got %0d exp 3", perf_flush_cnt); end
    checks++; if (perf_wait_cnt !== 32'd3) begin errors++; $display("FAIL perf_wait got %0d exp 3", perf_wait_cnt); end
`endif
  endtask

  task automatic test_reset_dwait();
    tick(); dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_dwait_pre got %0d exp 1", state); end
    #1 reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || outs !== 5'b00000) begin errors++; $display("FAIL rst_dwait got %0d/%b exp 0/00000", state, outs); end
    tick(); reset = 1'b1; clear_inputs();
    @(negedge clk);
    checks++; if (state !== 2'd0 || outs !== 5'b11000) begin errors++; $display("FAIL rst_dwait_post got %0d/%b exp 0/11000", state, outs); end
`ifdef HAZ_PERF_EN
    checks++; if ({perf_lu_cnt, perf_flush_cnt, perf_wait_cnt} !== 96'd0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d/%0d exp 0/0/0", perf_lu_cnt, perf_flush_cnt, perf_wait_cnt); end
`endif
  endtask

  task automatic test_timeout();
    tick(); dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) @(posedge clk);
    @(negedge clk);
    checks++; if (state !== 2'd1 || mem_timeout !== 1'b0) begin errors++; $display("FAIL pre_timeout got %0d/%b exp 1/0", state, mem_timeout); end
    @(posedge clk); #1 ex_branch_tkn = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd2 || mem_timeout !== 1'b1 || outs !== 5'b00001) begin
      errors++; $display("FAIL timeout got %0d/%b/%b exp 2/1/00001", state, mem_timeout, outs); end
    tick(); dmem_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd2 || mem_timeout !== 1'b1 || pc_write !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky got %0d/%b/%b exp 2/1/0", state, mem_timeout, pc_write); end
`ifdef HAZ_PERF_EN
    checks++; if (perf_wait_cnt !== 32'd16 || perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_frozen got %0d/%0d exp 16/0", perf_wait_cnt, perf_flush_cnt); end
`endif
    #2 reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || mem_timeout !== 1'b0 || outs !== 5'b00000) begin
      errors++; $display("FAIL timeout_reset got %0d/%b/%b exp 0/0/00000", state, mem_timeout, outs); end
    tick(); reset = 1'b1; clear_inputs();
  endtask

  initial begin
    test_reset();
    tick();
    test_load_use();
    test_zero_reg();
    test_branch_jump();
    test_mem_wait();
    test_reset_dwait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
